// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared opcode, stack command, error and state definitions for the RPN executor
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_PUSHI = 3'd0,
        OP_DUP   = 3'd1,
        OP_DROP  = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_AND   = 3'd5,
        OP_XOR   = 3'd6,
        OP_OUT   = 3'd7
    } op_e;

    localparam logic [1:0] STK_NONE = 2'b00;
    localparam logic [1:0] STK_PUSH = 2'b01;
    localparam logic [1:0] STK_POP  = 2'b10;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_BADOP     = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_ONLY,
        S_POP_ONLY,
        S_POP_A,
        S_POP_B,
        S_PUSH_RES,
        S_OUT_POP
    } state_e;

endpackage

// File: rtl/rpn_alu.sv
// rtl/rpn_alu.sv - combinational binary operator, b is the entry below top, a is top
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  op_e                   op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_AND:  result = b & a;
            OP_XOR:  result = b ^ a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_exec.sv
// rtl/rpn_stack_exec.sv - sequences push/pop commands to an external stack from RPN instruction tokens
module rpn_stack_exec
    import rpn_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int ADDR_WIDTH  = $clog2(STACK_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [2:0]            instr_op,
    input  logic [DATA_WIDTH-1:0] instr_imm,
    output logic                  stk_en,
    output logic [1:0]            stk_op,
    output logic [DATA_WIDTH-1:0] stk_d,
    input  logic [DATA_WIDTH-1:0] stk_top0,
    input  logic [DATA_WIDTH-1:0] stk_top1,
    input  logic [ADDR_WIDTH-1:0] stk_sp,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  err_valid,
    output logic [1:0]            err_code
);

    state_e                state, state_n;
    logic                  ready_n, en_n, rv_n, ev_n;
    logic [1:0]            op_n, ec_n;
    logic [DATA_WIDTH-1:0] d_n, rd_n, a_q, a_n, b_q, b_n, alu_res;
    op_e                   alu_op_q, alu_op_n, op_in;

    assign op_in = op_e'(instr_op);

    rpn_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op     (alu_op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_ready <= 1'b0;
            stk_en      <= 1'b0;
            stk_op      <= STK_NONE;
            stk_d       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            err_valid   <= 1'b0;
            err_code    <= ERR_NONE;
            a_q         <= '0;
            b_q         <= '0;
            alu_op_q    <= OP_ADD;
        end else begin
            state       <= state_n;
            instr_ready <= ready_n;
            stk_en      <= en_n;
            stk_op      <= op_n;
            stk_d       <= d_n;
            res_valid   <= rv_n;
            res_data    <= rd_n;
            err_valid   <= ev_n;
            err_code    <= ec_n;
            a_q         <= a_n;
            b_q         <= b_n;
            alu_op_q    <= alu_op_n;
        end
    end

    always_comb begin
        state_n  = state;
        ready_n  = instr_ready;
        en_n     = 1'b0;
        op_n     = STK_NONE;
        d_n      = stk_d;
        rv_n     = res_valid;
        rd_n     = res_data;
        ev_n     = 1'b0;
        ec_n     = err_code;
        a_n      = a_q;
        b_n      = b_q;
        alu_op_n = alu_op_q;
        case (state)
            S_IDLE: begin
                ready_n = 1'b1;
                if (instr_valid && instr_ready) begin
                    // Default to a consumed-with-error token; each legal case overrides it.
                    ev_n    = 1'b1;
                    ec_n    = ERR_UNDERFLOW;
                    case (op_in)
                        OP_PUSHI: if (!stk_full) begin
                            ev_n = 1'b0; ec_n = err_code; ready_n = 1'b0;
                            en_n = 1'b1; op_n = STK_PUSH; d_n = instr_imm; state_n = S_PUSH_ONLY;
                        end else ec_n = ERR_OVERFLOW;
                        OP_DUP: if (stk_empty) ec_n = ERR_UNDERFLOW;
                        else if (stk_full) ec_n = ERR_OVERFLOW;
                        else begin
                            ev_n = 1'b0; ec_n = err_code; ready_n = 1'b0;
                            en_n = 1'b1; op_n = STK_PUSH; d_n = stk_top0; state_n = S_PUSH_ONLY;
                        end
                        OP_DROP: if (!stk_empty) begin
                            ev_n = 1'b0; ec_n = err_code; ready_n = 1'b0;
                            en_n = 1'b1; op_n = STK_POP; state_n = S_POP_ONLY;
                        end
                        OP_OUT: if (!stk_empty) begin
                            ev_n = 1'b0; ec_n = err_code; ready_n = 1'b0;
                            en_n = 1'b1; op_n = STK_POP; state_n = S_OUT_POP;
                            rv_n = 1'b1; rd_n = stk_top0;
                        end
                        default: if (stk_sp >= ADDR_WIDTH'(2)) begin
                            ev_n = 1'b0; ec_n = err_code; ready_n = 1'b0;
                            en_n = 1'b1; op_n = STK_POP; state_n = S_POP_A;
                            a_n = stk_top0; b_n = stk_top1; alu_op_n = op_in;
                        end
                    endcase
                end
            end
            S_PUSH_ONLY, S_POP_ONLY, S_PUSH_RES: begin
                ready_n = 1'b1;
                state_n = S_IDLE;
            end
            S_POP_A: begin
                en_n    = 1'b1;
                op_n    = STK_POP;
                state_n = S_POP_B;
            end
            S_POP_B: begin
                en_n    = 1'b1;
                op_n    = STK_PUSH;
                d_n     = alu_res;
                state_n = S_PUSH_RES;
            end
            S_OUT_POP: begin
                if (res_ready) begin
                    rv_n    = 1'b0;
                    ready_n = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
